imem_loader: RTL and testbench

Boot-time writer for the core's 256-word instruction memory, which the core reads as word DATA[A[9:2]].
- Accepts a byte stream over a valid/ready handshake.
- Assembles little-endian 32-bit instruction words and writes them sequentially from byte address 0.
- Holds the core in reset until a complete image is loaded.

---
 rtl/imem_loader_if.sv | 28 ++
 rtl/imem_loader.sv | 217 +++++++++++++++++++++
 tb/tb_imem_loader.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// imem_loader_if: groups the imem_loader byte-stream handshake, the
// instruction-memory write port and the load status flags.
// slave  = the loader itself, master = the host/testbench side.
`timescale 1ns/1ps

interface imem_loader_if;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        WE;
  logic [31:0] WA;
  logic [31:0] WD;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_rst_n;

  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, WE, WA, WD, busy, done, err, cpu_rst_n
  );

  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, WE, WA, WD, busy, done, err, cpu_rst_n
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the core's instruction memory.
// Takes a byte stream (16-bit LE word count N, then N little-endian
// words), writes the words from byte address 0 upward, and keeps the
// core in reset (cpu_rst_n=0) until a complete image has been loaded.
// Optional feature macro: IMEM_LOADER_CKSUM_EN adds a trailing XOR
// checksum byte that must match all data bytes before DONE is reached.
`timescale 1ns/1ps

module imem_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  imem_loader_if.slave bus
);

  // One extra bit so the word counter can reach MAX_WORDS without wrapping.
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR0  = 3'd1,
    S_HDR1  = 3'd2,
    S_DATA  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5,
`ifdef IMEM_LOADER_CKSUM_EN
    S_ERR   = 3'd6,
    S_CHK   = 3'd7
`else
    S_ERR   = 3'd6
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        n_q, n_d;
  logic [CNT_W-1:0]   word_idx_q, word_idx_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [31:0]        wd_q, wd_d;
  logic [31:0]        wa_q, wa_d;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0]         cks_q, cks_d;
`endif

  logic        byte_ready;
  logic        we;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_rst_n;
  logic        xfer;
  logic [15:0] n_full;
  logic        last_word;

  assign xfer      = bus.byte_valid && byte_ready;
  // Full word count as it becomes known on the HDR1 transfer.
  assign n_full    = {bus.byte_data, n_q[7:0]};
  // True in WRITE when the word being written is the final one of the image.
  assign last_word = (32'(word_idx_q) + 32'd1) == 32'(n_q);

  // Output decode: every flag is a pure function of the current state.
  always_comb begin
    byte_ready = 1'b0;
    we         = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    cpu_rst_n  = 1'b0;
    case (state_q)
      S_HDR0, S_HDR1, S_DATA: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      S_WRITE: begin
        we   = 1'b1;
        busy = 1'b1;
      end
      S_DONE: begin
        done      = 1'b1;
        cpu_rst_n = 1'b1;
      end
      S_ERR: begin
        err = 1'b1;
      end
`ifdef IMEM_LOADER_CKSUM_EN
      S_CHK: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
`endif
      default: begin
        byte_ready = 1'b0;
      end
    endcase
  end

  // Next-state and datapath update: header capture, byte assembly, write sequencing.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    wd_d       = wd_q;
    wa_d       = wa_q;
`ifdef IMEM_LOADER_CKSUM_EN
    cks_d      = cks_q;
`endif
    case (state_q)
      // start is only honoured while not busy; it also clears the running XOR.
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.start) begin
          state_d = S_HDR0;
`ifdef IMEM_LOADER_CKSUM_EN
          cks_d   = 8'h00;
`endif
        end
      end
      S_HDR0: begin
        if (xfer) begin
          n_d[7:0] = bus.byte_data;
          state_d  = S_HDR1;
        end
      end
      S_HDR1: begin
        if (xfer) begin
          n_d = n_full;
          if (n_full == 16'd0) begin
`ifdef IMEM_LOADER_CKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_DONE;
`endif
          end else if (n_full > 16'(MAX_WORDS)) begin
            state_d = S_ERR;
          end else begin
            state_d    = S_DATA;
            word_idx_d = '0;
            byte_idx_d = 2'd0;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          wd_d[{byte_idx_q, 3'b000} +: 8] = bus.byte_data;
          byte_idx_d = byte_idx_q + 2'd1;
`ifdef IMEM_LOADER_CKSUM_EN
          cks_d      = cks_q ^ bus.byte_data;
`endif
          if (byte_idx_q == 2'd3) begin
            // Latch the address here so WA stays put after word_idx advances.
            state_d = S_WRITE;
            wa_d    = {{(30-ADDR_W){1'b0}}, word_idx_q[ADDR_W-1:0], 2'b00};
          end
        end
      end
      S_WRITE: begin
        word_idx_d = word_idx_q + CNT_W'(1);
        if (last_word) begin
`ifdef IMEM_LOADER_CKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d    = S_DATA;
          byte_idx_d = 2'd0;
        end
      end
`ifdef IMEM_LOADER_CKSUM_EN
      S_CHK: begin
        if (xfer) begin
          state_d = (bus.byte_data == cks_q) ? S_DONE : S_ERR;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; asynchronous reset returns everything to IDLE/zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      wd_q       <= '0;
      wa_q       <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
      cks_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      wd_q       <= wd_d;
      wa_q       <= wa_d;
`ifdef IMEM_LOADER_CKSUM_EN
      cks_q      <= cks_d;
`endif
    end
  end

  assign bus.byte_ready = byte_ready;
  assign bus.WE         = we;
  assign bus.WA         = wa_q;
  assign bus.WD         = wd_q;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.err        = err;
  assign bus.cpu_rst_n  = cpu_rst_n;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven vectors, hand sequences for reset/timing
// corners, and randomized images checked against a stream-level model.
`timescale 1ns/1ps

module tb_imem_loader;

  logic clk = 1'b0;
  logic rst_n;

  imem_loader_if bus();

  imem_loader #(.ADDR_W(8), .MAX_WORDS(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0]  stim_q[$];
  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];

  typedef struct {
    logic [127:0] stream;
    int           len;
    int           gap;
    int           nwe;
    logic [31:0]  wa0, wd0, wa1, wd1;
    logic         done_e, err_e;
  } vec_t;

  vec_t vt[$];

  localparam logic [127:0] IMG   = 128'h0140_0113_00A0_0093_0002;
  localparam logic [127:0] IMG_G = 128'h60_0140_0113_00A0_0093_0002;
  localparam logic [127:0] IMG_B = 128'h61_0140_0113_00A0_0093_0002;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Capture every memory write; byte_ready must be low and WA in range while WE is high.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.WE === 1'b1) begin
      got_q.push_back({bus.WA, bus.WD});
      chk("ready_low_in_write", 32'(bus.byte_ready), 32'd0);
      chk("wa_in_range", 32'(bus.WA <= 32'h3FC), 32'd1);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    bus.byte_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      bus.byte_data = 8'($urandom);
      @(posedge clk); #1;
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    t = 0;
    @(negedge clk);
    while (!bus.byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("byte_ready_wait", 32'(bus.byte_ready), 32'd1);
    @(posedge clk); #1;
    bus.byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  function automatic int gap_of(input int mode);
    if (mode == 0) return 0;
    if (mode == 1) return 1;
    return int'($urandom_range(0, 2));
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "/byte_ready"}, 32'(bus.byte_ready), 32'd0);
    chk({tag, "/WE"},         32'(bus.WE),         32'd0);
    chk({tag, "/WA"},         bus.WA,              32'd0);
    chk({tag, "/WD"},         bus.WD,              32'd0);
    chk({tag, "/busy"},       32'(bus.busy),       32'd0);
    chk({tag, "/done"},       32'(bus.done),       32'd0);
    chk({tag, "/err"},        32'(bus.err),        32'd0);
    chk({tag, "/cpu_rst_n"},  32'(bus.cpu_rst_n),  32'd0);
  endtask

  task automatic check_writes(input string tag);
    int m;
    chk({tag, "/we_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      chk($sformatf("%s/WA%0d", tag, i), got_q[i][63:32], exp_q[i][63:32]);
      chk($sformatf("%s/WD%0d", tag, i), got_q[i][31:0],  exp_q[i][31:0]);
    end
  endtask

  // Start a load, stream stim_q, then compare writes and final status.
  task automatic run_stream(input string tag, input int gap_mode,
                            input logic exp_done, input logic exp_err);
    got_q.delete();
    pulse_start();
    chk({tag, "/busy_after_start"}, 32'(bus.busy),      32'd1);
    chk({tag, "/err_after_start"},  32'(bus.err),       32'd0);
    chk({tag, "/done_after_start"}, 32'(bus.done),      32'd0);
    chk({tag, "/crst_after_start"}, 32'(bus.cpu_rst_n), 32'd0);
    foreach (stim_q[i]) send_byte(stim_q[i], gap_of(gap_mode));
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "/done"},       32'(bus.done),       32'(exp_done));
    chk({tag, "/err"},        32'(bus.err),        32'(exp_err));
    chk({tag, "/cpu_rst_n"},  32'(bus.cpu_rst_n),  32'(exp_done));
    chk({tag, "/busy_end"},   32'(bus.busy),       32'd0);
    chk({tag, "/ready_end"},  32'(bus.byte_ready), 32'd0);
    check_writes(tag);
  endtask

  // Stream-level reference: decode header, slice words, evaluate checksum.
  task automatic model(output logic ed, output logic ee);
    int n;
    int b;
    logic [7:0] x;
    exp_q.delete();
    ed = 1'b0;
    ee = 1'b0;
    n  = int'({stim_q[1], stim_q[0]});
    if (n > 256) begin
      ee = 1'b1;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      b = 2 + 4 * i;
      exp_q.push_back({32'(4 * i), stim_q[b+3], stim_q[b+2], stim_q[b+1], stim_q[b]});
      x = x ^ stim_q[b] ^ stim_q[b+1] ^ stim_q[b+2] ^ stim_q[b+3];
    end
`ifdef IMEM_LOADER_CKSUM_EN
    if (stim_q[2 + 4 * n] == x) ed = 1'b1;
    else                        ee = 1'b1;
`else
    ed = 1'b1;
`endif
  endtask

  task automatic gen_random(input int n, input bit good_ck);
    logic [7:0] b;
    logic [7:0] x;
    stim_q.delete();
    stim_q.push_back(n[7:0]);
    stim_q.push_back(n[15:8]);
    if (n <= 256) begin
      x = 8'h00;
      for (int i = 0; i < 4 * n; i++) begin
        b = 8'($urandom);
        stim_q.push_back(b);
        x = x ^ b;
      end
`ifdef IMEM_LOADER_CKSUM_EN
      stim_q.push_back(good_ck ? x : (x ^ 8'($urandom_range(1, 255))));
`else
      if (good_ck) b = x;
`endif
    end
  endtask

  initial begin
    logic [127:0] s;
    logic ed, ee;
    int   n;

`ifdef IMEM_LOADER_CKSUM_EN
    vt.push_back('{IMG_G, 11, 0, 2, 32'h0, 32'h00A00093, 32'h4, 32'h01400113, 1'b1, 1'b0});
    vt.push_back('{IMG_B, 11, 0, 2, 32'h0, 32'h00A00093, 32'h4, 32'h01400113, 1'b0, 1'b1});
    vt.push_back('{128'h00_0000, 3, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0});
    vt.push_back('{128'h0101, 2, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1});
    vt.push_back('{IMG_G, 11, 1, 2, 32'h0, 32'h00A00093, 32'h4, 32'h01400113, 1'b1, 1'b0});
`else
    vt.push_back('{IMG, 10, 0, 2, 32'h0, 32'h00A00093, 32'h4, 32'h01400113, 1'b1, 1'b0});
    vt.push_back('{128'h0000, 2, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0});
    vt.push_back('{128'h0101, 2, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1});
    vt.push_back('{IMG, 10, 1, 2, 32'h0, 32'h00A00093, 32'h4, 32'h01400113, 1'b1, 1'b0});
`endif

    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table vectors (error row is followed by a good image, so err recovery is covered).
    for (int v = 0; v < vt.size(); v++) begin
      s = vt[v].stream;
      stim_q.delete();
      for (int k = 0; k < vt[v].len; k++) stim_q.push_back(s[8*k +: 8]);
      exp_q.delete();
      if (vt[v].nwe > 0) exp_q.push_back({vt[v].wa0, vt[v].wd0});
      if (vt[v].nwe > 1) exp_q.push_back({vt[v].wa1, vt[v].wd1});
      run_stream($sformatf("vec%0d", v), vt[v].gap, vt[v].done_e, vt[v].err_e);
    end

    // N=0: done must be visible in the cycle right after the header completes.
    got_q.delete();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
`ifdef IMEM_LOADER_CKSUM_EN
    chk("n0/done_before_cks", 32'(bus.done), 32'd0);
    chk("n0/busy_in_chk",     32'(bus.busy), 32'd1);
    send_byte(8'h00, 0);
`endif
    chk("n0/done_next_cycle", 32'(bus.done), 32'd1);
    chk("n0/no_we", 32'(got_q.size()), 32'd0);

    // start pulsed mid-load must be ignored.
    got_q.delete();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    pulse_start();
    chk("busy_start/busy", 32'(bus.busy), 32'd1);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
`ifdef IMEM_LOADER_CKSUM_EN
    send_byte(8'h44, 0);
`endif
    repeat (3) @(posedge clk);
    #1;
    exp_q.delete();
    exp_q.push_back({32'h0, 32'h44332211});
    check_writes("busy_start");
    chk("busy_start/done", 32'(bus.done), 32'd1);

    // Asynchronous reset in the middle of word 0, then a clean reload.
    got_q.delete();
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h93, 0);
    send_byte(8'h00, 0);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    s = IMG_G;
    stim_q.delete();
`ifdef IMEM_LOADER_CKSUM_EN
    for (int k = 0; k < 11; k++) stim_q.push_back(s[8*k +: 8]);
`else
    for (int k = 0; k < 10; k++) stim_q.push_back(s[8*k +: 8]);
`endif
    exp_q.delete();
    exp_q.push_back({32'h0, 32'h00A00093});
    exp_q.push_back({32'h4, 32'h01400113});
    run_stream("after_reset", 0, 1'b1, 1'b0);

    // Largest legal image fills every word up to WA=0x3FC.
    gen_random(256, 1'b1);
    model(ed, ee);
    run_stream("max_words", 0, ed, ee);

    // Randomized images, lengths, checksum validity and valid gaps.
    for (int it = 0; it < 25; it++) begin
      case ($urandom_range(0, 9))
        0:       n = 257 + int'($urandom_range(0, 65278));
        1:       n = 0;
        default: n = int'($urandom_range(1, 6));
      endcase
      gen_random(n, $urandom_range(0, 3) != 0);
      model(ed, ee);
      run_stream($sformatf("rand%0d_n%0d", it, n), 2, ed, ee);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
